// File: rtl/sequence_detector_param_pkg.sv
// Shared constants for the sequence-detector family: default geometry and
// detection-mode encodings, plus a sizing helper for the fill counter.
package sequence_detector_pkg;

    localparam int                               DEFAULT_PATTERN_WIDTH = 4;
    localparam logic [DEFAULT_PATTERN_WIDTH-1:0] DEFAULT_PATTERN       = 4'b1011;
    localparam int                               DEFAULT_COUNT_WIDTH   = 8;

    localparam logic MODE_OVERLAP    = 1'b1;
    localparam logic MODE_NONOVERLAP = 1'b0;

    // Bits needed to hold 0..n inclusive.
    function automatic int fill_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sequence_detector_param_if.sv
// Bit-stream, control and result bundle between the serial source / event
// logic (master) and the parametrised sequence detector (slave).
interface sequence_detector_param_if #(
    parameter int PATTERN_WIDTH = 4,
    parameter int COUNT_WIDTH   = 8
);

    logic                     sequence_in;
    logic                     sequence_valid;
    logic [PATTERN_WIDTH-1:0] pattern_in;
    logic                     pattern_load;
    logic                     overlap_en;
    logic                     count_clear;
    logic                     detector_out;
    logic [COUNT_WIDTH-1:0]   match_count;

    modport master (
        output sequence_in, sequence_valid, pattern_in, pattern_load,
               overlap_en, count_clear,
        input  detector_out, match_count
    );

    modport slave (
        input  sequence_in, sequence_valid, pattern_in, pattern_load,
               overlap_en, count_clear,
        output detector_out, match_count
    );

endinterface

// File: rtl/sequence_detector_param_sat_counter.sv
// Saturating up-counter with synchronous active-low reset; clear beats
// increment and the count sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             clear,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/sequence_detector_param.sv
// Moore serial sequence detector with run-time reloadable pattern,
// overlap/non-overlap modes, valid-qualified input and saturating match count.
module sequence_detector_param #(
    parameter int                       PATTERN_WIDTH   = sequence_detector_pkg::DEFAULT_PATTERN_WIDTH,
    parameter logic [PATTERN_WIDTH-1:0] DEFAULT_PATTERN = sequence_detector_pkg::DEFAULT_PATTERN,
    parameter int                       COUNT_WIDTH     = sequence_detector_pkg::DEFAULT_COUNT_WIDTH
) (
    input logic                     clock,
    input logic                     reset,
    sequence_detector_param_if.slave bus
);

    import sequence_detector_pkg::*;

    localparam int             N         = PATTERN_WIDTH;
    localparam int             FW        = fill_width(N);
    localparam logic [FW-1:0]  FILL_FULL = FW'(N);

    logic [N-1:0]           history_q, history_d, history_shift;
    logic [N-1:0]           pattern_q, pattern_d;
    logic [FW-1:0]          fill_q, fill_d, fill_inc;
    logic                   detector_q, detector_d;
    logic                   match;
    logic [COUNT_WIDTH-1:0] count_w;

    always_comb begin
        history_shift = {history_q[N-2:0], bus.sequence_in};
        fill_inc      = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + 1'b1;
        // A load cycle discards the incoming bit, so it can never match.
        match         = bus.sequence_valid && !bus.pattern_load &&
                        (fill_inc == FILL_FULL) && (history_shift == pattern_q);

        history_d  = history_q;
        fill_d     = fill_q;
        pattern_d  = pattern_q;
        detector_d = detector_q;

        if (bus.pattern_load) begin
            pattern_d  = bus.pattern_in;
            history_d  = '0;
            fill_d     = '0;
            detector_d = 1'b0;
        end else if (bus.sequence_valid) begin
            history_d  = history_shift;
            detector_d = match;
            // Non-overlapping mode demands N fresh bits after each hit.
            if (match && (bus.overlap_en != MODE_OVERLAP)) begin
                fill_d = '0;
            end else begin
                fill_d = fill_inc;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            history_q  <= '0;
            fill_q     <= '0;
            pattern_q  <= DEFAULT_PATTERN;
            detector_q <= 1'b0;
        end else begin
            history_q  <= history_d;
            fill_q     <= fill_d;
            pattern_q  <= pattern_d;
            detector_q <= detector_d;
        end
    end

    sat_counter #(
        .WIDTH (COUNT_WIDTH)
    ) u_match_count (
        .clock (clock),
        .reset (reset),
        .inc   (match),
        .clear (bus.count_clear),
        .count (count_w)
    );

    assign bus.detector_out = detector_q;
    assign bus.match_count  = count_w;

endmodule

// File: doc/sequence_detector_param.md
# sequence_detector_param

Parametrised Moore-style serial sequence detector, successor to the fixed-pattern detector in the sequence-detector family. Pattern width, the reset-default pattern and the match-counter width are set at elaboration. The pattern is reloadable at run time. Overlapping and non-overlapping detection are both supported, and input bits are qualified by a valid strobe. It sits between the serial bit source and downstream event logic, and provides a registered match flag and a saturating match count.

## Interface
- `PATTERN_WIDTH`, default 4: number of bits in the pattern (N); legal range 2..32.
- `DEFAULT_PATTERN`, default 4'b1011: pattern loaded on reset; width `PATTERN_WIDTH`.
- `COUNT_WIDTH`, default 8: width of `match_count`.
- `clock` in, 1 bit: single clock; all state updates on the rising edge.
- `reset` in, 1 bit: synchronous, active-low reset.
- `sequence_in` in, 1 bit: serial data bit.
- `sequence_valid` in, 1 bit: `sequence_in` is sampled only when this is 1.
- `pattern_in` in, `PATTERN_WIDTH` bits: new pattern; bit N-1 is the first bit received.
- `pattern_load` in, 1 bit: load `pattern_in` and restart detection.
- `overlap_en` in, 1 bit: 1 selects overlapping detection, 0 selects non-overlapping.
- `count_clear` in, 1 bit: clear `match_count`.
- `detector_out` out, 1 bit: registered match flag (Moore).
- `match_count` out, `COUNT_WIDTH` bits: saturating count of matches.

## Operation
- **State registers:**
  - `history[N-1:0]`: newest bit in the LSB.
  - `fill`: 0..N, the number of valid bits accepted since the last restart.
  - `pattern_reg`
  - `detector_out`
  - `match_count`
- **Priority per edge:** `reset`=0, then `pattern_load`, then `sequence_valid`.
- **Reset (`reset`=0):**
  - `history`=0, `fill`=0, `pattern_reg`=`DEFAULT_PATTERN`.
  - `detector_out`=0, `match_count`=0.
- **Pattern load (`pattern_load`=1):**
  - `pattern_reg`<=`pattern_in`; `history`<=0; `fill`<=0; `detector_out`<=0.
  - `sequence_in` is ignored that cycle, even if valid.
  - `match_count` is unchanged.
- **Valid bit (`sequence_valid`=1):**
  - `history_next` = {`history`[N-2:0], `sequence_in`}.
  - `fill_next` = min(`fill`+1, N).
  - match = (`fill_next`==N) && (`history_next`==`pattern_reg`).
  - `detector_out`<=match.
  - On a match with `overlap_en`=0, `fill`<=0, so the next match needs N fresh bits.
  - On a match with `overlap_en`=1, `fill` stays at N.
- **Invalid cycle (`sequence_valid`=0):** `history`, `fill` and `detector_out` all hold. The Moore output stays high across idle cycles until the next valid bit.
- **Match counter:**
  - Increments by 1 on each edge where match=1.
  - Saturates at 2^`COUNT_WIDTH`-1 and never wraps.
  - `count_clear`=1 forces 0 and wins over a simultaneous increment.
  - `count_clear` is independent of `pattern_load`.
- **Mode changes:** `overlap_en` may change at any time. It only affects the `fill` update on a matching edge.
- **Bit ordering:** no partial or false match is possible before N valid bits have been accepted after a reset or load.

## Timing
- **Latency:** `detector_out` rises on the same edge that samples the last pattern bit. It is visible during the following cycle: one-cycle latency from the bit being presented.
- **Pulse width:** `detector_out` lasts from the matching edge up to and including the next valid-bit edge. Back-to-back valid bits therefore give a one-cycle pulse.
- **`match_count`:** updates on the same edge as `detector_out`.
- **`pattern_load`:** the new pattern takes effect for bits presented starting the cycle after the load.
- **Reset mid-stream:** all outputs are 0 on the first edge with `reset`=0, and detection restarts from an empty history.
- **Combinational paths:** none from inputs to outputs.

## Structure
- **Shared package `sequence_detector_pkg`:**
  - `DEFAULT_PATTERN_WIDTH`=4, `DEFAULT_PATTERN`=4'b1011, `DEFAULT_COUNT_WIDTH`=8.
  - Detection-mode constants `MODE_OVERLAP`=1, `MODE_NONOVERLAP`=0, shared with the fixed-pattern detectors.
- **Sub-module `sat_counter`:** parametrised `WIDTH`, with inputs `inc` and `clear`, synchronous active-low `reset`, clear-over-increment priority, and saturation at all-ones. It is instantiated once for `match_count`.
- **Top-level logic:** history shift register, fill counter, comparator and `detector_out` register.

## Test plan
All scenarios use the defaults (N=4, pattern 1011) unless stated otherwise.
1. **Reset:** hold `reset`=0 for 3 cycles with `sequence_valid`=1 and `sequence_in` toggling -> `detector_out`=0, `match_count`=0 throughout. Then release and send 1,0,1,1 -> `detector_out`=1 the cycle after the 4th bit, `match_count`=1.
2. **Overlap on:** `overlap_en`=1, stream 1,0,1,1,0,1,1 -> `detector_out` pulses after bits 4 and 7, `match_count`=2.
3. **Overlap off:** `overlap_en`=0, same stream -> single pulse after bit 4, `match_count`=1. The stream 1,0,1,1,1,0,1,1 -> 2 matches.
4. **Pattern reload:** send 1,0,1; pulse `pattern_load` with `pattern_in`=4'b0110 while `sequence_in`=1 and valid; then send 0,1,1,0 -> no match until after the 4th post-load bit. Earlier bits and the bit in the load cycle do not contribute; `match_count` is unchanged by the load.
5. **Valid gaps:** send 1,0 valid, then 3 cycles with `sequence_valid`=0 and `sequence_in`=0, then 1,1 valid -> match. `detector_out` holds 1 through 4 following idle cycles and drops on the next valid 0.
6. **Saturation and clear:** `COUNT_WIDTH`=2, 5 overlapping matches of 1011011011011011 -> `match_count`=3, never 0. Then assert `count_clear` on a matching edge -> `match_count`=0 and `detector_out`=1.
